// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries operands, indices and control into EX, detects
// load-use hazards, inserts bubbles on flush/hazard and counts hazard bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_W-1:0]  IF_ID_RS_i,
    input  logic [REG_W-1:0]  IF_ID_RT_i,
    input  logic [REG_W-1:0]  ID_RD_i,
    input  logic [DATA_W-1:0] ID_RSdata_i,
    input  logic [DATA_W-1:0] ID_RTdata_i,
    input  logic [DATA_W-1:0] ID_Imm_i,
    input  logic [CTRL_W-1:0] ID_Ctrl_i,
    input  logic              ID_Valid_i,
    input  logic              Flush_i,
    input  logic              Hold_i,
    output logic [REG_W-1:0]  ID_EX_RS_o,
    output logic [REG_W-1:0]  ID_EX_RT_o,
    output logic [REG_W-1:0]  ID_EX_RD_o,
    output logic [DATA_W-1:0] ID_EX_RSdata_o,
    output logic [DATA_W-1:0] ID_EX_RTdata_o,
    output logic [DATA_W-1:0] ID_EX_Imm_o,
    output logic [CTRL_W-1:0] ID_EX_Ctrl_o,
    output logic              ID_EX_Valid_o,
    output logic              PCWrite_o,
    output logic              IF_ID_Write_o,
    output logic [CNT_W-1:0]  BubbleCnt_o
);

    localparam int MEM_READ_BIT = 2;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             load_use;
    logic             stall;

    // A bubble has zero indices and MemRead clear, so it can never trigger a hazard.
    always_comb begin
        load_use = stage_q.valid & stage_q.ctrl[MEM_READ_BIT] & ID_Valid_i
                 & (stage_q.rd != '0)
                 & ((stage_q.rd == IF_ID_RS_i) | (stage_q.rd == IF_ID_RT_i));
        // Flush overrides the hazard stall so the redirect reaches IF.
        stall         = Hold_i | (load_use & ~Flush_i);
        PCWrite_o     = ~stall;
        IF_ID_Write_o = ~stall;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (Hold_i) begin
            stage_d      = stage_q;
        end else if (Flush_i) begin
            stage_d      = '0;
        end else if (load_use) begin
            stage_d      = '0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            stage_d.rs      = IF_ID_RS_i;
            stage_d.rt      = IF_ID_RT_i;
            stage_d.rd      = ID_RD_i;
            stage_d.rs_data = ID_RSdata_i;
            stage_d.rt_data = ID_RTdata_i;
            stage_d.imm     = ID_Imm_i;
            stage_d.ctrl    = ID_Ctrl_i;
            stage_d.valid   = ID_Valid_i;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ID_EX_RS_o     = stage_q.rs;
    assign ID_EX_RT_o     = stage_q.rt;
    assign ID_EX_RD_o     = stage_q.rd;
    assign ID_EX_RSdata_o = stage_q.rs_data;
    assign ID_EX_RTdata_o = stage_q.rt_data;
    assign ID_EX_Imm_o    = stage_q.imm;
    assign ID_EX_Ctrl_o   = stage_q.ctrl;
    assign ID_EX_Valid_o  = stage_q.valid;
    assign BubbleCnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: vector table plus scoreboard queue,
// hand sequences for reset mid-stall and counter saturation (narrow-counter instance).
module tb_id_ex_stage_reg;

    typedef enum logic [1:0] {CAP, BUB, KEEP} kind_e;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  ctrl;
        logic        valid, flush, hold;
        logic        pcw;
        kind_e       kind;
        logic [15:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  ctrl;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [8:0] LW  = 9'h007;
    localparam logic [8:0] ADD = 9'h041;

    logic        clk, rst;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [31:0] rsd_i, rtd_i, imm_i;
    logic [8:0]  ctrl_i;
    logic        valid_i, flush_i, hold_i;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [31:0] rsd_o, rtd_o, imm_o;
    logic [8:0]  ctrl_o;
    logic        valid_o, pcw_o, ifid_o;
    logic [15:0] cnt_o;
    logic [4:0]  s_rs_o, s_rt_o, s_rd_o;
    logic [31:0] s_rsd_o, s_rtd_o, s_imm_o;
    logic [8:0]  s_ctrl_o;
    logic        s_valid_o, s_pcw_o, s_ifid_o;
    logic [3:0]  s_cnt_o;

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];
    exp_t last_exp;
    vec_t vecs[$];

    id_ex_stage_reg dut (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RS_i(rs_i), .IF_ID_RT_i(rt_i), .ID_RD_i(rd_i),
        .ID_RSdata_i(rsd_i), .ID_RTdata_i(rtd_i), .ID_Imm_i(imm_i),
        .ID_Ctrl_i(ctrl_i), .ID_Valid_i(valid_i), .Flush_i(flush_i), .Hold_i(hold_i),
        .ID_EX_RS_o(rs_o), .ID_EX_RT_o(rt_o), .ID_EX_RD_o(rd_o),
        .ID_EX_RSdata_o(rsd_o), .ID_EX_RTdata_o(rtd_o), .ID_EX_Imm_o(imm_o),
        .ID_EX_Ctrl_o(ctrl_o), .ID_EX_Valid_o(valid_o),
        .PCWrite_o(pcw_o), .IF_ID_Write_o(ifid_o), .BubbleCnt_o(cnt_o)
    );

    // Same stimulus, 4-bit counter so saturation is reachable in a short run.
    id_ex_stage_reg #(.CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RS_i(rs_i), .IF_ID_RT_i(rt_i), .ID_RD_i(rd_i),
        .ID_RSdata_i(rsd_i), .ID_RTdata_i(rtd_i), .ID_Imm_i(imm_i),
        .ID_Ctrl_i(ctrl_i), .ID_Valid_i(valid_i), .Flush_i(flush_i), .Hold_i(hold_i),
        .ID_EX_RS_o(s_rs_o), .ID_EX_RT_o(s_rt_o), .ID_EX_RD_o(s_rd_o),
        .ID_EX_RSdata_o(s_rsd_o), .ID_EX_RTdata_o(s_rtd_o), .ID_EX_Imm_o(s_imm_o),
        .ID_EX_Ctrl_o(s_ctrl_o), .ID_EX_Valid_o(s_valid_o),
        .PCWrite_o(s_pcw_o), .IF_ID_Write_o(s_ifid_o), .BubbleCnt_o(s_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [8:0] ctrl, input logic valid, input logic flush,
                                input logic hold, input logic pcw, input kind_e kind,
                                input logic [15:0] cnt, input logic [31:0] rsd);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.ctrl = ctrl;
        v.valid = valid; v.flush = flush; v.hold = hold;
        v.pcw = pcw; v.kind = kind; v.cnt = cnt;
        v.rsd = rsd; v.rtd = $urandom; v.imm = $urandom;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs_i = v.rs; rt_i = v.rt; rd_i = v.rd;
        rsd_i = v.rsd; rtd_i = v.rtd; imm_i = v.imm;
        ctrl_i = v.ctrl; valid_i = v.valid; flush_i = v.flush; hold_i = v.hold;
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, "_rs"},    32'(rs_o),    32'(e.rs));
        check({tag, "_rt"},    32'(rt_o),    32'(e.rt));
        check({tag, "_rd"},    32'(rd_o),    32'(e.rd));
        check({tag, "_rsd"},   rsd_o,        e.rsd);
        check({tag, "_rtd"},   rtd_o,        e.rtd);
        check({tag, "_imm"},   imm_o,        e.imm);
        check({tag, "_ctrl"},  32'(ctrl_o),  32'(e.ctrl));
        check({tag, "_valid"}, 32'(valid_o), 32'(e.valid));
        check({tag, "_cnt"},   32'(cnt_o),   32'(e.cnt));
    endtask

    // Drive one vector, check the stall outputs, push the expected EX state,
    // then pop and compare once the edge has registered it.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        drive(v);
        #1;
        check({tag, "_pcwrite"},    32'(pcw_o),  32'(v.pcw));
        check({tag, "_ifid_write"}, 32'(ifid_o), 32'(v.pcw));
        case (v.kind)
            CAP: begin
                e.rs = v.rs; e.rt = v.rt; e.rd = v.rd;
                e.rsd = v.rsd; e.rtd = v.rtd; e.imm = v.imm;
                e.ctrl = v.ctrl; e.valid = v.valid;
            end
            BUB:     e = '0;
            default: e = last_exp;
        endcase
        e.cnt = v.cnt;
        last_exp = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag, sb.pop_front());
    endtask

    initial begin
        rst = 1'b1;
        drive(mk(0, 0, 0, 9'h0, 0, 0, 0, 1, CAP, 0, 32'h0));
        last_exp = '0;
        #12;
        compare("reset", '0);
        check("reset_pcwrite", 32'(pcw_o), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        vecs.push_back(mk(3, 4,  5, 9'h001, 1, 0, 0, 1, CAP,  0, 32'h11));
        vecs.push_back(mk(1, 2,  7, LW,     1, 0, 0, 1, CAP,  0, 32'h100));
        vecs.push_back(mk(7, 9, 10, ADD,    1, 0, 0, 0, BUB,  1, 32'h101));
        vecs.push_back(mk(7, 9, 10, ADD,    1, 0, 0, 1, CAP,  1, 32'h101));
        vecs.push_back(mk(0, 3,  0, LW,     1, 0, 0, 1, CAP,  1, 32'h102));
        vecs.push_back(mk(0, 0,  4, ADD,    1, 0, 0, 1, CAP,  1, 32'h103));
        vecs.push_back(mk(2, 3,  7, LW,     1, 0, 0, 1, CAP,  1, 32'h104));
        vecs.push_back(mk(6, 8,  9, ADD,    1, 0, 0, 1, CAP,  1, 32'h105));
        vecs.push_back(mk(2, 3,  7, LW,     1, 0, 0, 1, CAP,  1, 32'h106));
        vecs.push_back(mk(1, 7, 11, ADD,    0, 0, 0, 1, CAP,  1, 32'h107));
        vecs.push_back(mk(2, 3,  7, LW,     1, 0, 0, 1, CAP,  1, 32'h108));
        vecs.push_back(mk(7, 7, 12, ADD,    1, 1, 0, 1, BUB,  1, 32'h109));
        vecs.push_back(mk(2, 3,  7, LW,     1, 0, 0, 1, CAP,  1, 32'h10a));
        vecs.push_back(mk(7, 1, 12, ADD,    1, 1, 1, 0, KEEP, 1, 32'h10b));
        vecs.push_back(mk(7, 1, 12, ADD,    1, 0, 0, 0, BUB,  2, 32'h10c));
        vecs.push_back(mk(7, 1, 12, ADD,    1, 0, 0, 1, CAP,  2, 32'h10c));
        vecs.push_back(mk(4, 5,  6, ADD,    1, 0, 1, 0, KEEP, 2, 32'h10d));
        vecs.push_back(mk(1, 7,  7, LW,     1, 0, 0, 1, CAP,  2, 32'h10e));
        vecs.push_back(mk(3, 7, 14, ADD,    1, 0, 0, 0, BUB,  3, 32'h10f));
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted in the middle of a load-use stall.
        apply("rst_lw", mk(2, 3, 7, LW, 1, 0, 0, 1, CAP, 3, 32'h200));
        drive(mk(7, 1, 9, ADD, 1, 0, 0, 0, CAP, 0, 32'h201));
        #1;
        check("stall_before_rst", 32'(pcw_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        compare("rst_mid", '0);
        check("rst_mid_pcwrite",    32'(pcw_o),   32'd1);
        check("rst_mid_ifid_write", 32'(ifid_o),  32'd1);
        check("rst_mid_sat_cnt",    32'(s_cnt_o), 32'd0);
        hold_i = 1'b1;
        #1;
        check("rst_hold_pcwrite", 32'(pcw_o), 32'd0);
        hold_i = 1'b0;
        #1;
        rst = 1'b0;
        last_exp = '0;
        apply("post_rst", mk(7, 1, 9, ADD, 1, 0, 0, 1, CAP, 0, 32'h201));

        // Repeated load-use hazards: 16-bit counter tracks, 4-bit counter sticks at 15.
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("sat_lw%0d", i), mk(1, 2, 7, LW, 1, 0, 0, 1, CAP, 16'(i), 32'h300));
            apply($sformatf("sat_bub%0d", i), mk(7, 5, 8, ADD, 1, 0, 0, 0, BUB, 16'(i + 1), 32'h301));
            check($sformatf("sat_cnt%0d", i), 32'(s_cnt_o), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage core, sitting directly upstream of the EX-stage forwarding unit.
- Supplies the registered RS/RT/RD indices that the forwarding unit compares, plus the operands and control bits the EX stage consumes.
- Owns load-use hazard detection, bubble insertion, flush and global-hold handling.
- Keeps a saturating count of load-use bubbles it inserts.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register index width
- CTRL_W, 9, control bundle width. Bit map: [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite, [4] ALUSrc, [8:5] ALUOp
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- IF_ID_RS_i  in  REG_W  rs index of instruction in ID
- IF_ID_RT_i  in  REG_W  rt index of instruction in ID
- ID_RD_i  in  REG_W  destination index (RegDst already applied)
- ID_RSdata_i  in  DATA_W  register-file read data A
- ID_RTdata_i  in  DATA_W  register-file read data B
- ID_Imm_i  in  DATA_W  sign-extended immediate
- ID_Ctrl_i  in  CTRL_W  decoded control bundle
- ID_Valid_i  in  1  ID holds a real instruction
- Flush_i  in  1  branch/jump redirect resolved; kill ID instruction
- Hold_i  in  1  global freeze (memory not ready)
- ID_EX_RS_o  out  REG_W  registered rs, to forwarding unit
- ID_EX_RT_o  out  REG_W  registered rt, to forwarding unit
- ID_EX_RD_o  out  REG_W  registered rd
- ID_EX_RSdata_o  out  DATA_W  registered operand A
- ID_EX_RTdata_o  out  DATA_W  registered operand B
- ID_EX_Imm_o  out  DATA_W  registered immediate
- ID_EX_Ctrl_o  out  CTRL_W  registered control bundle
- ID_EX_Valid_o  out  1  EX holds a real instruction
- PCWrite_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register enable
- BubbleCnt_o  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst_i=1): all registered outputs 0, including Ctrl, Valid, RS/RT/RD and BubbleCnt. PCWrite_o=1 and IF_ID_Write_o=1 while reset is held, unless Hold_i=1.
- Load-use detect (combinational): LU = ID_EX_Valid_o & ID_EX_Ctrl_o[2] & ID_Valid_i & (ID_EX_RD_o != 0) & (ID_EX_RD_o == IF_ID_RS_i | ID_EX_RD_o == IF_ID_RT_i).
- Stall outputs (combinational):
  - PCWrite_o = IF_ID_Write_o = !(Hold_i | (LU & !Flush_i)).
  - Flush_i suppresses the load-use stall so the redirect proceeds.
- Register update on rising clk_i, first matching rule applies:
  1. Hold_i=1: all registers and the counter keep their values.
  2. Flush_i=1: insert bubble.
  3. LU=1: insert bubble and increment BubbleCnt_o. The counter saturates at all-ones and never wraps.
  4. Otherwise: capture all ID inputs; Valid <= ID_Valid_i.
- Bubble: Ctrl <= 0, Valid <= 0, RS/RT/RD <= 0. Data/imm registers are don't-care; the implementation clears them to 0.
  - Zeroed indices guarantee the forwarding unit never matches on a bubble.
- Latency: 1 cycle, ID inputs to outputs.
- A load-use stall lasts exactly one cycle. The bubble clears MemRead, so LU deasserts next cycle and the stalled instruction is then captured.
- ID_Valid_i=0 with no flush or hold: registers are captured as presented, and Valid=0 is propagated. LU cannot assert for an invalid ID instruction.
- A load to r0 never stalls.
- Reset asserted mid-stall or mid-hold: outputs clear immediately.
  - After release, the first edge follows the normal rules.
  - LU is 0 at that edge, since Valid=0 after reset.

Test Plan:
- Reset: assert rst_i mid-cycle with registers loaded -> all outputs 0 immediately, BubbleCnt_o=0, PCWrite_o=1.
- Pass-through: ID RS=3, RT=4, RD=5, RSdata=0x11, Ctrl=0x001, Valid=1, no hazards -> next edge ID_EX_RS_o=3, RT=4, RD=5, RSdata=0x11, Valid=1; PCWrite_o=1.
- Load-use: lw to r7 in EX (Ctrl[2]=1, RD=7, Valid=1), ID RS=7 -> PCWrite_o=IF_ID_Write_o=0 that cycle; next edge Ctrl=0, Valid=0, RD=0, BubbleCnt_o=1; the following edge captures the ID instruction and stall deasserts.
- No stall on r0 or on RD mismatch: lw RD=0 with ID RS=0 -> no stall. lw RD=7 with ID RS=6, RT=8 -> no stall, BubbleCnt_o unchanged.
- Flush beats load-use: LU condition true and Flush_i=1 -> PCWrite_o=1; next edge bubble; BubbleCnt_o unchanged.
- Hold priority and saturation: Hold_i=1 with LU and Flush_i both true -> PCWrite_o=0, registers and counter unchanged. Preset BubbleCnt_o=0xFFFF and trigger LU -> stays 0xFFFF.
